// File: rtl/ramp_gen_pkg.sv
// Shared constants for the ramp/triangle generator: mode encodings and default widths.
package ramp_gen_pkg;

    localparam logic [1:0] MODE_TRI   = 2'b00;
    localparam logic [1:0] MODE_SAWUP = 2'b01;
    localparam logic [1:0] MODE_SAWDN = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 8;
    localparam int DEF_DIV_W  = 16;

endpackage

// File: rtl/ramp_prescaler.sv
// Rate counter: raises adv once every div+1 enabled cycles; count freezes while en is low.
module ramp_prescaler
    import ramp_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             adv
);

    logic [DIV_W-1:0] count_reg;

    // >= rather than == so a shrinking div mid-count still advances promptly.
    assign adv = en && (count_reg >= div);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (en) begin
            if (adv) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ramp_wave_gen.sv
// Bounded triangle / sawtooth / hold waveform source with programmable step, bounds and rate.
module ramp_wave_gen
    import ramp_gen_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [DIV_W-1:0]  div,
    output logic [WIDTH-1:0]  wave,
    output logic              dir,
    output logic              tick,
    output logic              peak,
    output logic              trough
);

    logic adv;

    logic [WIDTH-1:0] wave_reg, wave_next;
    logic             dir_reg, dir_next;
    logic             tick_reg, tick_next;
    logic             peak_reg, peak_next;
    logic             trough_reg, trough_next;

    logic [WIDTH:0]   wave_ext, step_ext, lo_ext, hi_ext;
    logic [WIDTH:0]   sum, lo_plus;
    logic [WIDTH-1:0] diff;

    ramp_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .div (div),
        .adv (adv)
    );

    // One guard bit so wave+step and lo+step can never wrap.
    assign wave_ext = {1'b0, wave_reg};
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign lo_ext   = {1'b0, lo};
    assign hi_ext   = {1'b0, hi};
    assign sum      = wave_ext + step_ext;
    assign lo_plus  = lo_ext + step_ext;
    assign diff     = wave_reg - step_ext[WIDTH-1:0];

    always_comb begin
        wave_next   = wave_reg;
        dir_next    = dir_reg;
        tick_next   = adv;
        peak_next   = 1'b0;
        trough_next = 1'b0;
        if (adv) begin
            if (lo >= hi) begin
                wave_next = lo;
                dir_next  = 1'b1;
            end else if ((wave_reg < lo) || (wave_reg > hi)) begin
                wave_next   = lo;
                dir_next    = 1'b1;
                trough_next = 1'b1;
            end else if ((step == '0) || (mode == MODE_HOLD)) begin
                wave_next = wave_reg;
            end else begin
                case (mode)
                    MODE_TRI: begin
                        if (dir_reg) begin
                            if (sum >= hi_ext) begin
                                wave_next = hi;
                                dir_next  = 1'b0;
                                peak_next = 1'b1;
                            end else begin
                                wave_next = sum[WIDTH-1:0];
                            end
                        end else begin
                            if (wave_ext <= lo_plus) begin
                                wave_next   = lo;
                                dir_next    = 1'b1;
                                trough_next = 1'b1;
                            end else begin
                                wave_next = diff;
                            end
                        end
                    end
                    MODE_SAWUP: begin
                        dir_next = 1'b1;
                        if (sum > hi_ext) begin
                            wave_next   = lo;
                            trough_next = 1'b1;
                        end else begin
                            wave_next = sum[WIDTH-1:0];
                        end
                    end
                    MODE_SAWDN: begin
                        dir_next = 1'b0;
                        if (wave_ext < lo_plus) begin
                            wave_next = hi;
                            peak_next = 1'b1;
                        end else begin
                            wave_next = diff;
                        end
                    end
                    default: begin
                        wave_next = wave_reg;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wave_reg   <= '0;
            dir_reg    <= 1'b1;
            tick_reg   <= 1'b0;
            peak_reg   <= 1'b0;
            trough_reg <= 1'b0;
        end else begin
            wave_reg   <= wave_next;
            dir_reg    <= dir_next;
            tick_reg   <= tick_next;
            peak_reg   <= peak_next;
            trough_reg <= trough_next;
        end
    end

    assign wave   = wave_reg;
    assign dir    = dir_reg;
    assign tick   = tick_reg;
    assign peak   = peak_reg;
    assign trough = trough_reg;

endmodule

// File: tb/tb_ramp_wave_gen.sv
// Directed bench for ramp_wave_gen: each scenario task drives stimulus and checks hand-computed samples.
module tb_ramp_wave_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  step = 8'd0;
    logic [7:0]  lo = 8'd0;
    logic [7:0]  hi = 8'd0;
    logic [15:0] div = 16'd0;
    logic [7:0]  wave;
    logic        dir, tick, peak, trough;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    ramp_wave_gen #(.WIDTH(8), .STEP_W(8), .DIV_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .step   (step),
        .lo     (lo),
        .hi     (hi),
        .div    (div),
        .wave   (wave),
        .dir    (dir),
        .tick   (tick),
        .peak   (peak),
        .trough (trough)
    );

    // Advance one clock and settle just past the edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 2'b00; lo = 8'd0; hi = 8'd255; step = 8'd1; div = 16'd0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, dir, tick, peak, trough} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0})
                $display("FAIL reset[%0d] got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=0 dir=1 tick=0 peak=0 trough=0",
                         i, wave, dir, tick, peak, trough);
            else pass_cnt++;
            $display("reset[%0d] wave=%0d dir=%b", i, wave, dir);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_triangle();
        logic [7:0] ew;
        logic       ed, ep, et;
        int         bad;
        bad = 0;
        for (int k = 1; k <= 511; k++) begin
            step_clk();
            if (k <= 255) begin
                ew = 8'(k); ed = (k < 255); ep = (k == 255); et = 1'b0;
            end else begin
                ew = 8'(510 - k); ed = (k >= 510); ep = 1'b0; et = (k == 510);
            end
            if (k == 511) begin
                ew = 8'd1; ed = 1'b1;
            end
            chk_cnt++;
            if ({wave, dir, tick, peak, trough} !== {ew, ed, 1'b1, ep, et}) begin
                $display("FAIL full_tri cyc%0d got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=%0d dir=%b tick=1 peak=%b trough=%b",
                         k, wave, dir, tick, peak, trough, ew, ed, ep, et);
                bad++;
            end else pass_cnt++;
        end
        $display("full_tri 511 samples, %0d bad", bad);
    endtask

    task automatic test_bounded_triangle();
        logic [7:0] ew [8] = '{8'd10, 8'd14, 8'd18, 8'd20, 8'd16, 8'd12, 8'd10, 8'd14};
        logic [7:0] ed = 8'b1100_0111;
        logic [7:0] ep = 8'b0000_1000;
        logic [7:0] et = 8'b0100_0001;
        en = 1'b1; mode = 2'b00; lo = 8'd10; hi = 8'd20; step = 8'd4; div = 16'd0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, dir, tick, peak, trough} !== {ew[i], ed[i], 1'b1, ep[i], et[i]})
                $display("FAIL tri_bounds[%0d] got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=%0d dir=%b tick=1 peak=%b trough=%b",
                         i, wave, dir, tick, peak, trough, ew[i], ed[i], ep[i], et[i]);
            else pass_cnt++;
            $display("tri_bounds[%0d] wave=%0d dir=%b peak=%b trough=%b", i, wave, dir, peak, trough);
        end
    endtask

    task automatic test_sawup_div();
        logic [7:0] seq [5] = '{8'd30, 8'd60, 8'd90, 8'd0, 8'd30};
        logic [7:0] ew;
        logic       et;
        en = 1'b1; mode = 2'b01; lo = 8'd0; hi = 8'd100; step = 8'd30; div = 16'd2;
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            step_clk();
            ew = (c < 3) ? 8'd0 : seq[c / 3 - 1];
            et = (c % 3 == 0);
            chk_cnt++;
            if ({wave, dir, tick, peak, trough} !== {ew, 1'b1, et, 1'b0, (c == 12)})
                $display("FAIL sawup cyc%0d got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=%0d dir=1 tick=%b peak=0 trough=%b",
                         c, wave, dir, tick, peak, trough, ew, et, (c == 12));
            else pass_cnt++;
            $display("sawup cyc%0d wave=%0d tick=%b trough=%b", c, wave, tick, trough);
        end
    endtask

    task automatic test_sawdown_hold();
        logic [7:0] ew [6] = '{8'd50, 8'd60, 8'd57, 8'd54, 8'd51, 8'd60};
        logic [5:0] ed = 6'b00_0001;
        logic [5:0] ep = 6'b10_0010;
        logic [5:0] et = 6'b00_0001;
        en = 1'b1; mode = 2'b10; lo = 8'd50; hi = 8'd60; step = 8'd3; div = 16'd0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, dir, tick, peak, trough} !== {ew[i], ed[i], 1'b1, ep[i], et[i]})
                $display("FAIL sawdn[%0d] got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=%0d dir=%b tick=1 peak=%b trough=%b",
                         i, wave, dir, tick, peak, trough, ew[i], ed[i], ep[i], et[i]);
            else pass_cnt++;
            $display("sawdn[%0d] wave=%0d peak=%b", i, wave, peak);
        end
        mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, dir, tick, peak, trough} !== {8'd60, 1'b0, 1'b1, 1'b0, 1'b0})
                $display("FAIL hold[%0d] got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=60 dir=0 tick=1 peak=0 trough=0",
                         i, wave, dir, tick, peak, trough);
            else pass_cnt++;
            $display("hold[%0d] wave=%0d tick=%b", i, wave, tick);
        end
    endtask

    task automatic test_enable_freeze();
        logic [7:0] pre_w [5] = '{8'd0, 8'd5, 8'd5, 8'd10, 8'd10};
        logic [4:0] pre_t = 5'b01010;
        logic [7:0] post_w [4] = '{8'd15, 8'd15, 8'd20, 8'd20};
        logic [3:0] post_t = 4'b0101;
        en = 1'b1; mode = 2'b00; lo = 8'd0; hi = 8'd255; step = 8'd5; div = 16'd1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, tick} !== {pre_w[i], pre_t[i]})
                $display("FAIL en_pre[%0d] got wave=%0d tick=%b want wave=%0d tick=%b", i, wave, tick, pre_w[i], pre_t[i]);
            else pass_cnt++;
            $display("en_pre[%0d] wave=%0d tick=%b", i, wave, tick);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, tick, peak, trough} !== {8'd10, 1'b0, 1'b0, 1'b0})
                $display("FAIL en_off[%0d] got wave=%0d tick=%b peak=%b trough=%b want wave=10 tick=0 peak=0 trough=0",
                         i, wave, tick, peak, trough);
            else pass_cnt++;
            $display("en_off[%0d] wave=%0d tick=%b", i, wave, tick);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, tick} !== {post_w[i], post_t[i]})
                $display("FAIL en_post[%0d] got wave=%0d tick=%b want wave=%0d tick=%b", i, wave, tick, post_w[i], post_t[i]);
            else pass_cnt++;
            $display("en_post[%0d] wave=%0d tick=%b", i, wave, tick);
        end
    endtask

    task automatic test_midrun_reset_and_flat();
        en = 1'b1; mode = 2'b10; lo = 8'd0; hi = 8'd255; step = 8'd5; div = 16'd0;
        do_reset();
        for (int i = 0; i < 12; i++) step_clk();
        chk_cnt++;
        if ({wave, dir} !== {8'd200, 1'b0})
            $display("FAIL pre_rst got wave=%0d dir=%b want wave=200 dir=0", wave, dir);
        else pass_cnt++;
        $display("pre_rst wave=%0d dir=%b", wave, dir);
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        chk_cnt++;
        if ({wave, dir, tick, peak, trough} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL mid_rst got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=0 dir=1 tick=0 peak=0 trough=0",
                     wave, dir, tick, peak, trough);
        else pass_cnt++;
        $display("mid_rst wave=%0d dir=%b", wave, dir);
        mode = 2'b00; lo = 8'd40; hi = 8'd40; step = 8'd3;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            chk_cnt++;
            if ({wave, dir, tick, peak, trough} !== {8'd40, 1'b1, 1'b1, 1'b0, 1'b0})
                $display("FAIL flat[%0d] got wave=%0d dir=%b tick=%b peak=%b trough=%b want wave=40 dir=1 tick=1 peak=0 trough=0",
                         i, wave, dir, tick, peak, trough);
            else pass_cnt++;
            $display("flat[%0d] wave=%0d tick=%b", i, wave, tick);
        end
    endtask

    initial begin
        step_clk();
        test_reset();
        test_full_triangle();
        test_bounded_triangle();
        test_sawup_div();
        test_sawdown_hold();
        test_enable_freeze();
        test_midrun_reset_and_flat();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
